seg7_scan_driver: RTL



---
 rtl/seg7_scan_driver.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each digit is lit for REFRESH_DIV clocks, separated by GAP_CYCLES clocks
// with every anode off to prevent ghosting. The input word, decimal points
// and blanking mode are sampled once per frame when digit 0 comes up, so a
// frame never mixes two input values. All pin outputs come straight from
// flops that load on the same edge as the scan state change.
//
// Ports:
//   clk      - system clock
//   clr      - asynchronous active-high reset; display goes dark at once
//   value    - four hex digits, digit k = value[4k+3:4k], digit 0 rightmost
//   dp_in    - decimal point request per digit, active-high
//   blank_lz - 1 = blank leading zero digits (digit 0 is always shown)
//   an       - anode enables, active-low, an[k] = digit k
//   seg      - cathodes {g,f,e,d,c,b,a}, active-low
//   dp       - decimal point cathode, active-low
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GAP_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [15:0]     value_q, value_d;
    logic [3:0]      dp_q, dp_d;
    logic            blz_q, blz_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dpo_q, dpo_d;

    // Active-low gfedcba encoding of one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // The digit about to be lit. When it is digit 0 the frame latch loads on
    // the same edge, so the display data must bypass the latch and come
    // straight from the inputs; otherwise it comes from the latched frame.
    logic [1:0]  next_idx;
    logic        frame_start;
    logic [15:0] sel_value;
    logic [3:0]  sel_dp;
    logic        sel_blz;
    logic [3:0]  blank_vec;
    logic [3:0]  show_an;
    logic [6:0]  show_seg;
    logic        show_dp;

    assign next_idx    = idx_q + 2'd1;
    assign frame_start = (next_idx == 2'd0);
    assign sel_value   = frame_start ? value    : value_q;
    assign sel_dp      = frame_start ? dp_in    : dp_q;
    assign sel_blz     = frame_start ? blank_lz : blz_q;

    // Digit k is a leading zero when it and every digit above it are zero.
    assign blank_vec[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_blank
            assign blank_vec[gi] = sel_blz & (sel_value[15:4*gi] == '0);
        end
    endgenerate

    always_comb begin
        show_an  = ~(4'b0001 << next_idx);
        show_seg = hex_to_seg(sel_value[{next_idx, 2'b00} +: 4]);
        show_dp  = ~sel_dp[next_idx];
        if (blank_vec[next_idx]) begin
            show_an  = 4'b1111;
            show_seg = 7'h7F;
            show_dp  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        gap_d   = gap_q;
        value_d = value_q;
        dp_d    = dp_q;
        blz_d   = blz_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dpo_d   = dpo_q;
        case (state_q)
            ST_SHOW: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    state_d = ST_GAP;
                    an_d    = 4'b1111;
                    seg_d   = 7'h7F;
                    dpo_d   = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    idx_d   = next_idx;
                    state_d = ST_SHOW;
                    an_d    = show_an;
                    seg_d   = show_seg;
                    dpo_d   = show_dp;
                    if (frame_start) begin
                        value_d = value;
                        dp_d    = dp_in;
                        blz_d   = blank_lz;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_GAP;
            idx_q   <= 2'd3;
            presc_q <= '0;
            gap_q   <= '0;
            value_q <= '0;
            dp_q    <= '0;
            blz_q   <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
            dpo_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            gap_q   <= gap_d;
            value_q <= value_d;
            dp_q    <= dp_d;
            blz_q   <= blz_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dpo_q   <= dpo_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dpo_q;

endmodule
